// File: rtl/data_buffer_writer.sv
// Write-side controller for the circular data buffer: parses length-prefixed
// packets, writes payload words at wrapping addresses, and publishes committed words.
module data_buffer_writer #(
   parameter int buffer_size = 1024,
   parameter int data_width  = 32
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [data_width-1:0]                                 in_data,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   output logic                                                  wr_en,
   output logic [((buffer_size <= 1) ? 1 : $clog2(buffer_size))-1:0] wr_addr_data,
   output logic [data_width-1:0]                                 wr_data,
   input  logic                                                  rd_release,
   input  logic [((buffer_size <= 1) ? 1 : $clog2(buffer_size)):0]   rd_release_cnt,
   output logic [((buffer_size <= 1) ? 1 : $clog2(buffer_size)):0]   population,
   output logic [((buffer_size <= 1) ? 1 : $clog2(buffer_size)):0]   free_space,
   output logic                                                  pkt_done,
   output logic                                                  err_oversize,
   output logic                                                  err_underflow
);

   localparam int AW     = (buffer_size <= 1) ? 1 : $clog2(buffer_size);
   localparam int BUF_I  = buffer_size;
   localparam int LAST_I = buffer_size - 1;
   localparam logic [AW:0]   BUF_SIZE = BUF_I[AW:0];
   localparam logic [AW-1:0] PTR_LAST = LAST_I[AW-1:0];

   typedef enum logic [1:0] {IDLE, DATA, COMMIT} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           ptr_q, ptr_d;
   logic [AW-1:0]           wr_addr_q, wr_addr_d;
   logic [data_width-1:0]   wr_data_q, wr_data_d;
   logic                    wr_en_q, wr_en_d;
   logic [AW:0]             population_q, population_d;
   logic [AW:0]             reserved_q, reserved_d;
   logic [AW:0]             remaining_q, remaining_d;
   logic                    pkt_done_q, pkt_done_d;
   logic                    err_oversize_q, err_oversize_d;
   logic                    err_underflow_q, err_underflow_d;

   logic [AW:0]             hdr_len;
   logic                    hdr_oversize;
   logic                    hdr_fits;
   logic [AW:0]             free_space_w;
   logic                    ready_w;
   logic                    accept;
   logic signed [AW+1:0]    pop_sum;

   // Wrap by explicit compare so non-power-of-2 buffers work.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      if (p == PTR_LAST) return '0;
      return p + 1'b1;
   endfunction

   function automatic logic [AW:0] clamp_pop(input logic signed [AW+1:0] v);
      if (v < 0) return '0;
      return v[AW:0];
   endfunction

   assign hdr_len      = in_data[AW:0];
   assign free_space_w = BUF_SIZE - population_q - reserved_q;
   assign hdr_oversize = (hdr_len > BUF_SIZE);
   assign hdr_fits     = (hdr_len <= free_space_w);

   always_comb begin
      ready_w = 1'b0;
      case (state_q)
         IDLE:    ready_w = hdr_fits | hdr_oversize;
         DATA:    ready_w = 1'b1;
         default: ready_w = 1'b0;
      endcase
      ready_w = ready_w & rst;
   end

   assign accept = in_valid & ready_w;

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      wr_addr_d       = wr_addr_q;
      wr_data_d       = wr_data_q;
      wr_en_d         = 1'b0;
      pkt_done_d      = 1'b0;
      reserved_d      = reserved_q;
      remaining_d     = remaining_q;
      err_oversize_d  = err_oversize_q;
      err_underflow_d = err_underflow_q;

      // Commit and release combine in one signed sum, then clamp at zero.
      pop_sum = $signed({1'b0, population_q});
      if (state_q == COMMIT) pop_sum = pop_sum + $signed({1'b0, reserved_q});
      if (rd_release) pop_sum = pop_sum - $signed({1'b0, rd_release_cnt});
      population_d = clamp_pop(pop_sum);
      if (pop_sum < 0) err_underflow_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (hdr_oversize) begin
                  err_oversize_d = 1'b1;
               end else if (hdr_len == '0) begin
                  reserved_d = '0;
                  state_d    = COMMIT;
               end else begin
                  reserved_d  = hdr_len;
                  remaining_d = hdr_len;
                  state_d     = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               wr_en_d     = 1'b1;
               wr_data_d   = in_data;
               wr_addr_d   = ptr_q;
               ptr_d       = next_ptr(ptr_q);
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == 1) state_d = COMMIT;
            end
         end
         COMMIT: begin
            pkt_done_d = 1'b1;
            reserved_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset wins over everything, dropping any partly written packet.
      if (!rst) begin
         state_d         = IDLE;
         ptr_d           = '0;
         wr_addr_d       = '0;
         wr_data_d       = '0;
         wr_en_d         = 1'b0;
         pkt_done_d      = 1'b0;
         population_d    = '0;
         reserved_d      = '0;
         remaining_d     = '0;
         err_oversize_d  = 1'b0;
         err_underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_en_q         <= wr_en_d;
      pkt_done_q      <= pkt_done_d;
      population_q    <= population_d;
      reserved_q      <= reserved_d;
      remaining_q     <= remaining_d;
      err_oversize_q  <= err_oversize_d;
      err_underflow_q <= err_underflow_d;
   end

   assign in_ready      = ready_w;
   assign wr_en         = wr_en_q;
   assign wr_addr_data  = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign population    = population_q;
   assign free_space    = free_space_w;
   assign pkt_done      = pkt_done_q;
   assign err_oversize  = err_oversize_q;
   assign err_underflow = err_underflow_q;

endmodule
